// File: rtl/writeback_unit.sv
// writeback_unit: merges queued ALU and load results onto one register-file write port,
// load-first with ALU anti-starvation, plus a 32-entry pending-write scoreboard.
module writeback_unit #(
    parameter int ALU_DEPTH = 4,
    parameter int LD_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AluValid,
    input  logic [4:0]  AluRd,
    input  logic [63:0] AluData,
    output logic        AluReady,
    input  logic        LoadValid,
    input  logic [4:0]  LoadRd,
    input  logic [63:0] LoadData,
    output logic        LoadReady,
    input  logic        IssueValid,
    input  logic [4:0]  IssueRd,
    output logic [31:0] BusyMask,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [63:0] WriteData
);
    localparam int AAW = $clog2(ALU_DEPTH);
    localparam int LAW = $clog2(LD_DEPTH);
    localparam logic [AAW:0] ALU_FULL = (AAW+1)'(ALU_DEPTH);
    localparam logic [LAW:0] LD_FULL  = (LAW+1)'(LD_DEPTH);

    logic [4:0]   r_alu_rd   [ALU_DEPTH];
    logic [63:0]  r_alu_data [ALU_DEPTH];
    logic [AAW-1:0] r_alu_wp, r_alu_rp;
    logic [AAW:0]   r_alu_cnt;
    logic [4:0]   r_ld_rd   [LD_DEPTH];
    logic [63:0]  r_ld_data [LD_DEPTH];
    logic [LAW-1:0] r_ld_wp, r_ld_rp;
    logic [LAW:0]   r_ld_cnt;
    logic [1:0]   r_starve;

    logic        w_alu_push, w_ld_push, w_alu_ne, w_ld_ne, w_pop_alu, w_pop_ld, w_wr;
    logic [4:0]  w_pop_rd;
    logic [63:0] w_pop_data;
    logic [31:0] w_set, w_clr;

    assign AluReady   = r_alu_cnt < ALU_FULL;
    assign LoadReady  = r_ld_cnt < LD_FULL;
    assign w_alu_push = AluValid && AluReady;
    assign w_ld_push  = LoadValid && LoadReady;
    assign w_alu_ne   = r_alu_cnt != '0;
    assign w_ld_ne    = r_ld_cnt != '0;
    // After three load grants in a row with ALU work waiting, the ALU head wins once.
    assign w_pop_alu  = w_alu_ne && (!w_ld_ne || r_starve == 2'd3);
    assign w_pop_ld   = w_ld_ne && !w_pop_alu;
    assign w_pop_rd   = w_pop_ld ? r_ld_rd[r_ld_rp] : r_alu_rd[r_alu_rp];
    assign w_pop_data = w_pop_ld ? r_ld_data[r_ld_rp] : r_alu_data[r_alu_rp];
    assign w_wr       = (w_pop_ld || w_pop_alu) && w_pop_rd != 5'd0;
    assign w_set      = (IssueValid && IssueRd != 5'd0) ? (32'd1 << IssueRd) : 32'd0;
    assign w_clr      = w_wr ? (32'd1 << w_pop_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_alu_rd[r_alu_wp]   <= AluRd;
            r_alu_data[r_alu_wp] <= AluData;
        end
        if (w_ld_push) begin
            r_ld_rd[r_ld_wp]   <= LoadRd;
            r_ld_data[r_ld_wp] <= LoadData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_wp  <= '0;
            r_alu_rp  <= '0;
            r_alu_cnt <= '0;
            r_ld_wp   <= '0;
            r_ld_rp   <= '0;
            r_ld_cnt  <= '0;
            r_starve  <= 2'd0;
            BusyMask  <= 32'd0;
            RegWrite  <= 1'b0;
            WriteReg  <= 5'd0;
            WriteData <= 64'd0;
        end else begin
            if (w_alu_push) r_alu_wp <= r_alu_wp + 1'b1;
            if (w_pop_alu)  r_alu_rp <= r_alu_rp + 1'b1;
            if (w_ld_push)  r_ld_wp  <= r_ld_wp + 1'b1;
            if (w_pop_ld)   r_ld_rp  <= r_ld_rp + 1'b1;
            r_alu_cnt <= r_alu_cnt + (AAW+1)'(w_alu_push) - (AAW+1)'(w_pop_alu);
            r_ld_cnt  <= r_ld_cnt + (LAW+1)'(w_ld_push) - (LAW+1)'(w_pop_ld);
            if (!w_alu_ne || w_pop_alu) r_starve <= 2'd0;
            else if (w_pop_ld)          r_starve <= r_starve + 2'd1;
            // Set after clear: a newly issued producer keeps the register busy.
            BusyMask <= (BusyMask & ~w_clr) | w_set;
            RegWrite <= w_wr;
            if (w_wr) begin
                WriteReg  <= w_pop_rd;
                WriteData <= w_pop_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scenario tasks with hand-computed expectations for writeback_unit.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        AluValid = 1'b0, LoadValid = 1'b0, IssueValid = 1'b0;
    logic [4:0]  AluRd = '0, LoadRd = '0, IssueRd = '0;
    logic [63:0] AluData = '0, LoadData = '0;
    logic        AluReady, LoadReady, RegWrite;
    logic [31:0] BusyMask;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    int errors = 0;
    int checks = 0;

    writeback_unit dut (
        .clk(clk), .rst_n(rst_n),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .LoadValid(LoadValid), .LoadRd(LoadRd), .LoadData(LoadData), .LoadReady(LoadReady),
        .IssueValid(IssueValid), .IssueRd(IssueRd), .BusyMask(BusyMask),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        AluValid = 1'b0; LoadValid = 1'b0; IssueValid = 1'b0;
        AluRd = '0; LoadRd = '0; IssueRd = '0; AluData = '0; LoadData = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        checks++; if (WriteReg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %0d want 0", WriteReg); end
        checks++; if (WriteData !== 64'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", WriteData); end
        checks++; if (BusyMask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", BusyMask); end
        checks++; if (AluReady !== 1'b1 || LoadReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got alu=%b ld=%b want 1 1", AluReady, LoadReady); end
        do_reset();
    endtask

    task automatic test_single_alu();
        AluValid = 1'b1; AluRd = 5'd5; AluData = 64'h1234;
        step();
        idle_inputs();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_early: RegWrite got %b want 0", RegWrite); end
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 64'h1234) begin errors++; $display("FAIL single_write: got rw=%b reg=%0d data=%h want 1 5 1234", RegWrite, WriteReg, WriteData); end
        step();
        checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd5 || WriteData !== 64'h1234) begin errors++; $display("FAIL single_hold: got rw=%b reg=%0d data=%h want 0 5 1234", RegWrite, WriteReg, WriteData); end
        do_reset();
    endtask

    task automatic test_load_priority();
        AluValid = 1'b1; AluRd = 5'd3; AluData = 64'hA3;
        LoadValid = 1'b1; LoadRd = 5'd4; LoadData = 64'hB4;
        step();
        idle_inputs();
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 64'hB4) begin errors++; $display("FAIL prio_first: got rw=%b reg=%0d data=%h want 1 4 b4", RegWrite, WriteReg, WriteData); end
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 64'hA3) begin errors++; $display("FAIL prio_second: got rw=%b reg=%0d data=%h want 1 3 a3", RegWrite, WriteReg, WriteData); end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL prio_done: RegWrite got %b want 0", RegWrite); end
        do_reset();
    endtask

    task automatic test_starvation();
        logic [4:0] exp_rd [5] = '{5'd10, 5'd11, 5'd12, 5'd9, 5'd13};
        for (int k = 0; k < 6; k++) begin
            LoadValid = 1'b1; LoadRd = 5'(10 + k); LoadData = 64'(100 + k);
            AluValid = (k == 0); AluRd = 5'd9; AluData = 64'h99;
            step();
            if (k >= 1) begin
                checks++; if (RegWrite !== 1'b1 || WriteReg !== exp_rd[k-1]) begin errors++; $display("FAIL starve_edge%0d: got rw=%b reg=%0d want 1 %0d", k, RegWrite, WriteReg, exp_rd[k-1]); end
            end
            if (k == 4) begin
                checks++; if (LoadReady !== 1'b0) begin errors++; $display("FAIL starve_ldfull: LoadReady got %b want 0", LoadReady); end
            end
        end
        idle_inputs();
        do_reset();
    endtask

    task automatic test_alu_full();
        logic [4:0] exp_rd [5] = '{5'd20, 5'd33, 5'd21, 5'd22, 5'd23};
        for (int k = 0; k < 5; k++) begin
            AluValid = 1'b1; AluRd = 5'(20 + k); AluData = 64'(200 + k);
            LoadValid = (k < 4); LoadRd = 5'(30 + k); LoadData = 64'(300 + k);
            step();
            if (k == 2) begin
                checks++; if (AluReady !== 1'b1) begin errors++; $display("FAIL full_three: AluReady got %b want 1", AluReady); end
            end
            if (k == 3) begin
                checks++; if (AluReady !== 1'b0) begin errors++; $display("FAIL full_four: AluReady got %b want 0", AluReady); end
            end
        end
        idle_inputs();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== exp_rd[0] || WriteData !== 64'd200) begin errors++; $display("FAIL full_drain0: got rw=%b reg=%0d data=%0d want 1 20 200", RegWrite, WriteReg, WriteData); end
        for (int k = 1; k < 5; k++) begin
            step();
            checks++; if (RegWrite !== 1'b1 || WriteReg !== exp_rd[k]) begin errors++; $display("FAIL full_drain%0d: got rw=%b reg=%0d want 1 %0d", k, RegWrite, WriteReg, exp_rd[k]); end
        end
        step();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL full_no_fifth: got rw=%b reg=%0d want 0", RegWrite, WriteReg); end
        do_reset();
    endtask

    task automatic test_scoreboard();
        IssueValid = 1'b1; IssueRd = 5'd7;
        step();
        checks++; if (BusyMask !== 32'h80) begin errors++; $display("FAIL sb_set7: got %h want 00000080", BusyMask); end
        IssueRd = 5'd8; AluValid = 1'b1; AluRd = 5'd7; AluData = 64'd77;
        step();
        checks++; if (BusyMask !== 32'h180) begin errors++; $display("FAIL sb_set8: got %h want 00000180", BusyMask); end
        IssueRd = 5'd7; AluRd = 5'd8; AluData = 64'd88;
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7) begin errors++; $display("FAIL sb_ret7: got rw=%b reg=%0d want 1 7", RegWrite, WriteReg); end
        checks++; if (BusyMask !== 32'h180) begin errors++; $display("FAIL sb_set_wins: got %h want 00000180", BusyMask); end
        idle_inputs();
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || BusyMask !== 32'h80) begin errors++; $display("FAIL sb_clear8: got rw=%b reg=%0d busy=%h want 1 8 00000080", RegWrite, WriteReg, BusyMask); end
        IssueValid = 1'b1; IssueRd = 5'd0; AluValid = 1'b1; AluRd = 5'd0; AluData = 64'hDEAD;
        step();
        idle_inputs();
        checks++; if (BusyMask !== 32'h80) begin errors++; $display("FAIL sb_issue0: got %h want 00000080", BusyMask); end
        step();
        checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd8 || WriteData !== 64'd88 || BusyMask !== 32'h80) begin errors++; $display("FAIL sb_write0: got rw=%b reg=%0d data=%0d busy=%h want 0 8 88 00000080", RegWrite, WriteReg, WriteData, BusyMask); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        IssueValid = 1'b1; IssueRd = 5'd12;
        AluValid = 1'b1; AluRd = 5'd12; AluData = 64'd1;
        LoadValid = 1'b1; LoadRd = 5'd13; LoadData = 64'd2;
        step();
        idle_inputs();
        step();
        checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd13 || BusyMask !== 32'h1000) begin errors++; $display("FAIL mid_pre: got rw=%b reg=%0d busy=%h want 1 13 00001000", RegWrite, WriteReg, BusyMask); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0 || BusyMask !== 32'd0 || WriteReg !== 5'd0) begin errors++; $display("FAIL mid_async: got rw=%b busy=%h reg=%0d want 0 0 0", RegWrite, BusyMask, WriteReg); end
        checks++; if (AluReady !== 1'b1 || LoadReady !== 1'b1) begin errors++; $display("FAIL mid_ready: got alu=%b ld=%b want 1 1", AluReady, LoadReady); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_after%0d: RegWrite got %b reg=%0d want 0", k, RegWrite, WriteReg); end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_load_priority();
        test_starvation();
        test_alu_full();
        test_scoreboard();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
